ysyx_24090012_wbu: RTL and testbench

Write-back unit of the multi-cycle NPC core. Accepts one executed instruction from EXU/LSU, writes the GPR file, and forwards CSR writes and ECALL traps to the CSR unit over its valid/ready port. It then hands the next PC to IFU, so the CSR state is up to date before the next fetch.

---
 rtl/ysyx_24090012_pkg.sv | 20 ++
 rtl/ysyx_24090012_wbu.sv | 145 ++++++++++++++
 tb/tb_ysyx_24090012_wbu.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24090012_pkg.sv
// Shared NPC definitions: WBU FSM states, machine-mode CSR addresses and trap causes.
package ysyx_24090012_pkg;

    typedef enum logic [1:0] {
        WBU_IDLE    = 2'd0,
        WBU_EXEC    = 2'd1,
        WBU_CSR_REQ = 2'd2,
        WBU_COMMIT  = 2'd3
    } wbu_state_t;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MVENDORID = 12'hf11;
    localparam logic [11:0] CSR_MARCHID   = 12'hf12;

    localparam logic [31:0] CAUSE_ECALL_M = 32'h0000000b;

endpackage

// File: rtl/ysyx_24090012_wbu.sv
// Write-back unit: GPR write, CSR/ECALL forwarding, then next-PC hand-off to IFU.
// Optional retire counter enabled by YSYX_24090012_WBU_RETIRE_CNT_EN.
module ysyx_24090012_wbu
    import ysyx_24090012_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_dnpc,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_rd_wdata,
    input  logic        in_rd_wen,
    input  logic [11:0] in_csr_addr,
    input  logic [31:0] in_csr_wdata,
    input  logic        in_csr_wen,
    input  logic        in_is_ecall,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_wen,
    output logic        wbu_csr_valid,
    input  logic        wbu_csr_ready,
    output logic [11:0] wbu_csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_wen,
    output logic        is_ecall,
    output logic [31:0] pc,
    output logic        commit_valid,
    input  logic        commit_ready,
    output logic [31:0] commit_dnpc
`ifdef YSYX_24090012_WBU_RETIRE_CNT_EN
    ,
    output logic [63:0] retire_cnt
`endif
);

    wbu_state_t  state;
    logic [31:0] pc_q;
    logic [31:0] dnpc_q;
    logic [4:0]  rd_q;
    logic [31:0] rd_wdata_q;
    logic [11:0] csr_addr_q;
    logic [31:0] csr_wdata_q;
    logic        csr_wen_q;
    logic        is_ecall_q;
    logic        rf_wen_q;
    logic        csr_valid_q;
    logic        commit_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= WBU_IDLE;
            pc_q           <= '0;
            dnpc_q         <= '0;
            rd_q           <= '0;
            rd_wdata_q     <= '0;
            csr_addr_q     <= '0;
            csr_wdata_q    <= '0;
            csr_wen_q      <= 1'b0;
            is_ecall_q     <= 1'b0;
            rf_wen_q       <= 1'b0;
            csr_valid_q    <= 1'b0;
            commit_valid_q <= 1'b0;
        end else begin
            case (state)
                WBU_IDLE: begin
                    if (in_valid) begin
                        pc_q        <= in_pc;
                        dnpc_q      <= in_dnpc;
                        rd_q        <= in_rd;
                        rd_wdata_q  <= in_rd_wdata;
                        csr_addr_q  <= in_csr_addr;
                        csr_wdata_q <= in_csr_wdata;
                        csr_wen_q   <= in_csr_wen;
                        is_ecall_q  <= in_is_ecall;
                        // Strobe decided at accept so it is a clean flop output in EXEC.
                        rf_wen_q    <= in_rd_wen && (in_rd != '0);
                        state       <= WBU_EXEC;
                    end
                end
                WBU_EXEC: begin
                    rf_wen_q <= 1'b0;
                    if (csr_wen_q || is_ecall_q) begin
                        csr_valid_q <= 1'b1;
                        state       <= WBU_CSR_REQ;
                    end else begin
                        commit_valid_q <= 1'b1;
                        state          <= WBU_COMMIT;
                    end
                end
                WBU_CSR_REQ: begin
                    if (wbu_csr_ready) begin
                        csr_valid_q    <= 1'b0;
                        commit_valid_q <= 1'b1;
                        state          <= WBU_COMMIT;
                    end
                end
                WBU_COMMIT: begin
                    if (commit_ready) begin
                        commit_valid_q <= 1'b0;
                        state          <= WBU_IDLE;
                    end
                end
                default: begin
                    rf_wen_q       <= 1'b0;
                    csr_valid_q    <= 1'b0;
                    commit_valid_q <= 1'b0;
                    state          <= WBU_IDLE;
                end
            endcase
        end
    end

    // Reset held low must also hide the IDLE-state ready.
    assign in_ready      = rst && (state == WBU_IDLE);

    assign rf_wen        = rf_wen_q;
    assign wbu_csr_valid = csr_valid_q;
    assign commit_valid  = commit_valid_q;

    assign rf_waddr      = rd_q;
    assign rf_wdata      = rd_wdata_q;
    assign wbu_csr_addr  = csr_addr_q;
    assign csr_wdata     = csr_wdata_q;
    assign csr_wen       = csr_wen_q;
    assign is_ecall      = is_ecall_q;
    assign pc            = pc_q;
    assign commit_dnpc   = dnpc_q;

`ifdef YSYX_24090012_WBU_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt_q <= '0;
        end else if (commit_valid_q && commit_ready) begin
            retire_cnt_q <= retire_cnt_q + 64'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_24090012_wbu.sv
// Scoreboard bench for ysyx_24090012_wbu: GPR, CSR and commit traffic checked in order.
module tb_ysyx_24090012_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_dnpc;
    logic [4:0]  in_rd;
    logic [31:0] in_rd_wdata;
    logic        in_rd_wen;
    logic [11:0] in_csr_addr;
    logic [31:0] in_csr_wdata;
    logic        in_csr_wen;
    logic        in_is_ecall;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wen;
    logic        wbu_csr_valid;
    logic        wbu_csr_ready;
    logic [11:0] wbu_csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_wen;
    logic        is_ecall;
    logic [31:0] pc;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_dnpc;
`ifdef YSYX_24090012_WBU_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_24090012_wbu dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_dnpc       (in_dnpc),
        .in_rd         (in_rd),
        .in_rd_wdata   (in_rd_wdata),
        .in_rd_wen     (in_rd_wen),
        .in_csr_addr   (in_csr_addr),
        .in_csr_wdata  (in_csr_wdata),
        .in_csr_wen    (in_csr_wen),
        .in_is_ecall   (in_is_ecall),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .rf_wen        (rf_wen),
        .wbu_csr_valid (wbu_csr_valid),
        .wbu_csr_ready (wbu_csr_ready),
        .wbu_csr_addr  (wbu_csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_wen       (csr_wen),
        .is_ecall      (is_ecall),
        .pc            (pc),
        .commit_valid  (commit_valid),
        .commit_ready  (commit_ready),
        .commit_dnpc   (commit_dnpc)
`ifdef YSYX_24090012_WBU_RETIRE_CNT_EN
        ,
        .retire_cnt    (retire_cnt)
`endif
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wdata;
    } rf_exp_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic        ecall;
        logic [31:0] pc;
    } csr_exp_t;

    typedef struct packed {
        logic [31:0] dnpc;
        logic        via_csr;
    } cm_exp_t;

    rf_exp_t  rf_q[$];
    csr_exp_t csr_q[$];
    cm_exp_t  cm_q[$];

    int unsigned     n_cmp = 0;
    int unsigned     n_err = 0;
    int              cyc = 0;
    int              acc_cyc = 0;
    int              hs_cyc = 0;
    logic            cm_pending = 1'b0;
    logic            csr_pending = 1'b0;
    longint unsigned exp_retire = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Inputs change #1 after posedge, so the negedge sees a settled picture.
    always @(negedge clk) begin
        if (rst) begin
            if (in_valid && in_ready) acc_cyc = cyc;
            if (rf_wen) begin
                if (rf_q.size() == 0) begin
                    check("rf_unexpected", 64'(rf_wen), 64'd0);
                end else begin
                    rf_exp_t e;
                    e = rf_q.pop_front();
                    check("rf_waddr", 64'(rf_waddr), 64'(e.rd));
                    check("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
                    check("rf_latency", 64'(cyc), 64'(acc_cyc + 1));
                end
            end
            if (wbu_csr_valid) begin
                check("in_ready_in_csr", 64'(in_ready), 64'd0);
                if (csr_q.size() == 0) begin
                    check("csr_unexpected", 64'(wbu_csr_valid), 64'd0);
                end else begin
                    csr_exp_t c;
                    c = csr_q[0];
                    if (!csr_pending) check("csr_latency", 64'(cyc), 64'(acc_cyc + 2));
                    check("csr_addr", 64'(wbu_csr_addr), 64'(c.addr));
                    check("csr_wdata", 64'(csr_wdata), 64'(c.wdata));
                    check("csr_wen", 64'(csr_wen), 64'(c.wen));
                    check("csr_ecall", 64'(is_ecall), 64'(c.ecall));
                    check("csr_pc", 64'(pc), 64'(c.pc));
                    if (wbu_csr_ready) begin
                        void'(csr_q.pop_front());
                        hs_cyc = cyc;
                    end
                end
            end
            csr_pending = wbu_csr_valid && !wbu_csr_ready;
            if (commit_valid) begin
                check("in_ready_in_commit", 64'(in_ready), 64'd0);
                if (cm_q.size() == 0) begin
                    check("commit_unexpected", 64'(commit_valid), 64'd0);
                end else begin
                    cm_exp_t m;
                    m = cm_q[0];
                    check("commit_dnpc", 64'(commit_dnpc), 64'(m.dnpc));
                    if (!cm_pending)
                        check("commit_latency", 64'(cyc), 64'(m.via_csr ? hs_cyc + 1 : acc_cyc + 2));
                    if (commit_ready) begin
                        void'(cm_q.pop_front());
                        exp_retire++;
                    end
                end
            end
            cm_pending = commit_valid && !commit_ready;
        end
    end

    // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
    task automatic send(input logic [31:0] s_pc, input logic [31:0] s_dnpc,
                        input logic [4:0] s_rd, input logic [31:0] s_wd, input logic s_rwen,
                        input logic [11:0] s_ca, input logic [31:0] s_cw,
                        input logic s_cwen, input logic s_ecall);
        int w;
        in_pc        = s_pc;
        in_dnpc      = s_dnpc;
        in_rd        = s_rd;
        in_rd_wdata  = s_wd;
        in_rd_wen    = s_rwen;
        in_csr_addr  = s_ca;
        in_csr_wdata = s_cw;
        in_csr_wen   = s_cwen;
        in_is_ecall  = s_ecall;
        in_valid     = 1'b1;
        if (s_rwen && s_rd != 5'd0) rf_q.push_back('{rd: s_rd, wdata: s_wd});
        if (s_cwen || s_ecall)
            csr_q.push_back('{addr: s_ca, wdata: s_cw, wen: s_cwen, ecall: s_ecall, pc: s_pc});
        cm_q.push_back('{dnpc: s_dnpc, via_csr: s_cwen || s_ecall});
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((rf_q.size() + csr_q.size() + cm_q.size()) != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        check("drain_left", 64'(rf_q.size() + csr_q.size() + cm_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_rf_wen"}, 64'(rf_wen), 64'd0);
        check({tag, "_csr_valid"}, 64'(wbu_csr_valid), 64'd0);
        check({tag, "_commit_valid"}, 64'(commit_valid), 64'd0);
        check({tag, "_payload"},
              {rf_waddr, rf_wdata[26:0]} | 64'(wbu_csr_addr) | 64'(csr_wdata) | 64'(pc) |
              64'(commit_dnpc) | 64'({csr_wen, is_ecall, rf_wdata[31:27]}), 64'd0);
    endtask

    initial begin
        rst           = 1'b0;
        in_valid      = 1'b0;
        in_pc         = '0;
        in_dnpc       = '0;
        in_rd         = '0;
        in_rd_wdata   = '0;
        in_rd_wen     = 1'b0;
        in_csr_addr   = '0;
        in_csr_wdata  = '0;
        in_csr_wen    = 1'b0;
        in_is_ecall   = 1'b0;
        wbu_csr_ready = 1'b1;
        commit_ready  = 1'b1;
        #3;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_valids", 64'({rf_wen, wbu_csr_valid, commit_valid}), 64'd0);
        check("rst_dnpc", 64'(commit_dnpc), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_rst");
        @(posedge clk);
        #1;

        // ADDI x5
        send(32'h8000_0000, 32'h8000_0004, 5'd5, 32'h1234, 1'b1, 12'h0, 32'h0, 1'b0, 1'b0);
        // write to x0 is dropped but still commits
        send(32'h8000_0004, 32'h8000_0008, 5'd0, 32'hdead, 1'b1, 12'h0, 32'h0, 1'b0, 1'b0);
        drain();

        // CSRRW mtvec with CSR stalled for 3 cycles
        wbu_csr_ready = 1'b0;
        send(32'h8000_0008, 32'h8000_000c, 5'd7, 32'h11, 1'b1, 12'h305, 32'h8000_1000, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        wbu_csr_ready = 1'b1;
        drain();

        // ECALL, then ECALL together with a CSR write
        send(32'h8000_0010, 32'h8000_1000, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1);
        send(32'h8000_0014, 32'h8000_1000, 5'd3, 32'h55, 1'b1, 12'h341, 32'habcd, 1'b1, 1'b1);
        drain();

        // commit stall
        commit_ready = 1'b0;
        send(32'h8000_0020, 32'h8000_0024, 5'd9, 32'hcafe, 1'b1, 12'h0, 32'h0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        commit_ready = 1'b1;
        drain();

        // back-to-back mix
        begin
            longint unsigned base;
            base = exp_retire;
            for (int i = 0; i < 10; i++) begin
                logic c;
                c = ($urandom_range(0, 2) == 0);
                send($urandom, $urandom, 5'($urandom), $urandom, 1'($urandom), 12'($urandom),
                     $urandom, c, 1'b0);
            end
            drain();
`ifdef YSYX_24090012_WBU_RETIRE_CNT_EN
            check("retire_10", retire_cnt, 64'(base + 10));
`else
            check("retire_model_10", 64'(exp_retire), 64'(base + 10));
`endif
        end

        // reset while in CSR_REQ
        wbu_csr_ready = 1'b0;
        send(32'h8000_0030, 32'h8000_0034, 5'd4, 32'h77, 1'b1, 12'h300, 32'h8, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_csr_valid", 64'(wbu_csr_valid), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_valids", 64'({rf_wen, wbu_csr_valid, commit_valid}), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        rf_q.delete();
        csr_q.delete();
        cm_q.delete();
        exp_retire  = 0;
        cm_pending  = 1'b0;
        csr_pending = 1'b0;
        @(posedge clk);
        #1;
        rst           = 1'b1;
        wbu_csr_ready = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_midrst");
`ifdef YSYX_24090012_WBU_RETIRE_CNT_EN
        check("retire_after_rst", retire_cnt, 64'd0);
`endif
        @(posedge clk);
        #1;

        send(32'h8000_0040, 32'h8000_0044, 5'd31, 32'hffff_ffff, 1'b1, 12'h0, 32'h0, 1'b0, 1'b0);
        drain();
`ifdef YSYX_24090012_WBU_RETIRE_CNT_EN
        check("retire_final", retire_cnt, 64'(exp_retire));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
